pt5_stream_fetcher: RTL and testbench

Parametrised successor to the fixed 3-byte/15-lane fetch path. It holds a weight bank and an input bank of PT-5 packed words, and walks a strided frame of DEPTH words. It unpacks every byte into 5 trits per bank and streams lane vectors through a valid/ready output with backpressure. It sits between the AXI loader (host write port) and the vector engine, and replaces the combinational start-gated address mux with a proper sequencer.

---
 rtl/tf_pkg.sv | 30 +++
 rtl/pt5_word_unpack.sv | 41 ++++
 rtl/pt5_stream_fetcher.sv | 205 ++++++++++++++++++++
 tb/tb_pt5_stream_fetcher.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tf_pkg : trit encodings, PT-5 limit and fetcher FSM states        |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
package tf_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  localparam logic [7:0] PT5_MAX = 8'd242;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  function automatic logic [1:0] trit_enc(input logic [1:0] d);
    case (d)
      2'd0:    trit_enc = TRIT_ZERO;
      2'd1:    trit_enc = TRIT_POS;
      default: trit_enc = TRIT_NEG;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pt5_word_unpack.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pt5_word_unpack : combinational PT-5 word to 2-bit trit lanes     |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module pt5_word_unpack
  import tf_pkg::*;
#(
  parameter int unsigned BYTES = 3
) (
  input  logic [8*BYTES-1:0]  word,
  output logic [10*BYTES-1:0] trits,
  output logic                invalid
);

  logic [BYTES-1:0] byte_bad;

  for (genvar b = 0; b < BYTES; b++) begin : g_byte
    logic [7:0] rem;
    logic [9:0] lanes;

    // Peel base-3 digits least significant first; an out-of-range byte yields zero lanes.
    always_comb begin
      rem         = word[8*b +: 8];
      lanes       = '0;
      byte_bad[b] = (rem > PT5_MAX);
      if (!byte_bad[b]) begin
        for (int k = 0; k < 5; k++) begin
          lanes[2*k +: 2] = trit_enc(2'(rem % 8'd3));
          rem             = rem / 8'd3;
        end
      end
    end

    assign trits[10*b +: 10] = lanes;
  end

  assign invalid = |byte_bad;

endmodule
`default_nettype wire

// File: rtl/pt5_stream_fetcher.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pt5_stream_fetcher : strided PT-5 frame walker with trit stream   |
// | Optional macro TF_PERF_CNT_EN adds perf_stall_cnt. Revision: 1.0  |
// +-------------------------------------------------------------------+
module pt5_stream_fetcher
  import tf_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned BYTES    = 3,
  parameter int unsigned DEPTH_W  = 16,
  parameter int unsigned STRIDE_W = 8,
  parameter int unsigned FIFO_D   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [DEPTH_W-1:0]    cfg_depth,
  input  logic [STRIDE_W-1:0]   cfg_stride,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [8*BYTES-1:0]    host_wdata,
  input  logic                  host_we_w,
  input  logic                  host_we_i,
  output logic                  host_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*BYTES-1:0]   out_weights,
  output logic [10*BYTES-1:0]   out_inputs,
  output logic                  out_last,
  output logic                  err_invalid
`ifdef TF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int unsigned LANES  = 5*BYTES;
  localparam int unsigned WORD_W = 8*BYTES;
  localparam int unsigned TRIT_W = 2*LANES;
  localparam int unsigned PTR_W  = $clog2(FIFO_D);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = 2*TRIT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DEPTH_W-1:0]    left_q, left_d;
  logic [STRIDE_W-1:0]   stride_q, stride_d;
  logic                  err_q, err_d;
  logic                  rd_v_q, rd_v_d, rd_last_q, rd_last_d;
  logic                  up_v_q, up_v_d, up_last_q, up_last_d;
  logic [TRIT_W-1:0]     up_w_q, up_w_d, up_i_q, up_i_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;

  logic [WORD_W-1:0]     wbank [2**ADDR_W];
  logic [WORD_W-1:0]     ibank [2**ADDR_W];
  logic [WORD_W-1:0]     bank_w_dout, bank_i_dout;
  logic [ENT_W-1:0]      fifo_mem [FIFO_D];

  logic [TRIT_W-1:0]     w_trits, i_trits;
  logic                  w_bad, i_bad;
  logic [CNT_W-1:0]      occ;
  logic                  issue, push, pop, head_last;
  logic [ENT_W-1:0]      head;

  // Reads still in the pipeline count against FIFO space so a full FIFO can never be overrun.
  assign occ   = cnt_q + CNT_W'(rd_v_q) + CNT_W'(up_v_q);
  assign issue = (state_q == ST_RUN) && (occ < CNT_W'(FIFO_D));
  assign push  = up_v_q;
  assign pop   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (host_we_w && host_ready) wbank[host_addr] <= host_wdata;
    if (host_we_i && host_ready) ibank[host_addr] <= host_wdata;
    if (issue) begin
      bank_w_dout <= wbank[addr_q];
      bank_i_dout <= ibank[addr_q];
    end
  end

  pt5_word_unpack #(.BYTES(BYTES)) u_unpack_w (
    .word(bank_w_dout), .trits(w_trits), .invalid(w_bad)
  );
  pt5_word_unpack #(.BYTES(BYTES)) u_unpack_i (
    .word(bank_i_dout), .trits(i_trits), .invalid(i_bad)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    stride_d = stride_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = cfg_base;
          left_d   = cfg_depth;
          stride_d = cfg_stride;
          err_d    = 1'b0;
          state_d  = (cfg_depth == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(stride_q);
          left_d = left_q - DEPTH_W'(1);
          if (left_q == DEPTH_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (pop && head_last) state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
    if (rd_v_q && (w_bad || i_bad)) err_d = 1'b1;
  end

  always_comb begin
    rd_v_d    = issue;
    rd_last_d = issue && (left_q == DEPTH_W'(1));
    up_v_d    = rd_v_q;
    up_last_d = rd_last_q;
    up_w_d    = w_trits;
    up_i_d    = i_trits;
    cnt_d     = cnt_q;
    wptr_d    = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d    = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      stride_q  <= '0;
      err_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_last_q <= 1'b0;
      up_v_q    <= 1'b0;
      up_last_q <= 1'b0;
      up_w_q    <= '0;
      up_i_q    <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      stride_q  <= stride_d;
      err_q     <= err_d;
      rd_v_q    <= rd_v_d;
      rd_last_q <= rd_last_d;
      up_v_q    <= up_v_d;
      up_last_q <= up_last_d;
      up_w_q    <= up_w_d;
      up_i_q    <= up_i_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= {up_last_q, up_w_q, up_i_q};
  end

  // Storage is not reset, so the data outputs are gated to read zero whenever nothing is valid.
  assign head        = fifo_mem[rptr_q];
  assign head_last   = head[ENT_W-1];
  assign out_valid   = (cnt_q != '0);
  assign out_last    = out_valid && head_last;
  assign out_weights = out_valid ? head[2*TRIT_W-1:TRIT_W] : '0;
  assign out_inputs  = out_valid ? head[TRIT_W-1:0] : '0;

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign host_ready  = (state_q == ST_IDLE);
  assign err_invalid = err_q;

`ifdef TF_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start) stall_d = '0;
    else if ((state_q == ST_RUN || state_q == ST_DRAIN) && out_valid && !out_ready &&
             (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pt5_stream_fetcher.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_pt5_stream_fetcher : scoreboard bench with base-3 model        |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module tb_pt5_stream_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cfg_base;
  logic [15:0] cfg_depth;
  logic [7:0]  cfg_stride;
  logic        start;
  logic        busy, done;
  logic [11:0] host_addr;
  logic [23:0] host_wdata;
  logic        host_we_w, host_we_i, host_ready;
  logic        out_valid, out_ready, out_last, err_invalid;
  logic [29:0] out_weights, out_inputs;
`ifdef TF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  pt5_stream_fetcher #(
    .ADDR_W(12), .BYTES(3), .DEPTH_W(16), .STRIDE_W(8), .FIFO_D(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_base(cfg_base), .cfg_depth(cfg_depth), .cfg_stride(cfg_stride),
    .start(start), .busy(busy), .done(done),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_we_w(host_we_w), .host_we_i(host_we_i), .host_ready(host_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_weights(out_weights), .out_inputs(out_inputs),
    .out_last(out_last), .err_invalid(err_invalid)
`ifdef TF_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;
  int rcnt = 0;
  int beats_acc = 0;
  int stall_model = 0;
  logic [23:0] mw [4096];
  logic [23:0] mi [4096];
  logic [60:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Lane values straight from the base-3 definition of each byte.
  function automatic logic [29:0] unpack_ref(input logic [23:0] w, output bit is_bad);
    logic [29:0] r;
    int v, d;
    r = '0;
    is_bad = 0;
    for (int b = 0; b < 3; b++) begin
      v = int'(w[8*b +: 8]);
      if (v > 242) is_bad = 1;
      else begin
        for (int k = 0; k < 5; k++) begin
          d = (v / (3**k)) % 3;
          r[2*(5*b+k) +: 2] = (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b11;
        end
      end
    end
    return r;
  endfunction

  function automatic bit push_frame(input int base, input int depth, input int stride);
    bit e, b1, b2;
    logic [29:0] w, i;
    int a;
    e = 0;
    for (int k = 0; k < depth; k++) begin
      a = (base + k*stride) % 4096;
      w = unpack_ref(mw[a], b1);
      i = unpack_ref(mi[a], b2);
      e = e | b1 | b2;
      exp_q.push_back({(k == depth-1) ? 1'b1 : 1'b0, w, i});
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (rcnt % 3 == 0);
        rcnt++;
      end
    endcase
  end

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  bit          hold_pend = 0;
  bit          chk_done_next = 0;
  logic [60:0] hold_val;
  logic [60:0] exp_beat;
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 0;
      chk_done_next = 0;
    end else begin
      if (chk_done_next) begin
        chk("done_after_last", done, 1);
        chk_done_next = 0;
      end
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_last, out_weights, out_inputs}, hold_val);
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_weights, out_inputs};
      if (busy && out_valid && !out_ready) stall_model++;
      if (out_valid && out_ready) begin
        beats_acc++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", {out_last, out_weights, out_inputs});
        end else begin
          exp_beat = exp_q.pop_front();
          chk("beat", {out_last, out_weights, out_inputs}, exp_beat);
          if (exp_beat[60]) chk_done_next = 1;
        end
      end
    end
  end

  task automatic host_write(input int a, input logic [23:0] d, input bit ww, input bit wi);
    host_addr  = 12'(a);
    host_wdata = d;
    host_we_w  = ww;
    host_we_i  = wi;
    @(posedge clk); #1;
    host_we_w  = 0;
    host_we_i  = 0;
    if (ww) mw[a] = d;
    if (wi) mi[a] = d;
  endtask

  task automatic run_frame(input int base, input int depth, input int stride,
                           input bit chk_lat, input bit poke);
    bit e_err;
    int n;
    e_err = push_frame(base, depth, stride);
    stall_model = 0;
    cfg_base   = 12'(base);
    cfg_depth  = 16'(depth);
    cfg_stride = 8'(stride);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    if (depth == 0) begin
      chk("depth0_done", done, 1);
      chk("depth0_valid", out_valid, 0);
    end
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (chk_lat && n == 2) chk("lat_early", out_valid, 0);
      if (chk_lat && n == 3) chk("lat_first", out_valid, 1);
      if (poke && n == 2) begin
        start      = 1;
        cfg_depth  = 16'd7;
        host_addr  = 12'h010;
        host_wdata = ~mw[12'h010];
        host_we_w  = 1;
        chk("host_ready_busy", host_ready, 0);
      end
      if (poke && n == 3) begin
        start     = 0;
        host_we_w = 0;
      end
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk("done_pulse_end", {busy, done}, 2'b00);
    chk("frame_leftover", exp_q.size(), 0);
    chk("err_invalid", err_invalid, e_err);
`ifdef TF_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, stall_model);
`endif
  endtask

  initial begin
    int n, dcnt;
    bit e;
    reset = 1; start = 0;
    cfg_base = '0; cfg_depth = '0; cfg_stride = '0;
    host_addr = '0; host_wdata = '0; host_we_w = 0; host_we_i = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", err_invalid, 0);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_weights", out_weights, 0);
    chk("rst_inputs", out_inputs, 0);
    reset = 0;

    for (int a = 0; a < 4096; a++) host_write(a, 24'($urandom), 1, 1);
    for (int a = 0; a < 4096; a++) host_write(a, 24'($urandom), 0, 1);

    host_write(0, 24'h000001, 1, 0);
    run_frame(0, 1, 1, 1, 0);

    host_write(5, 24'h0000F2, 1, 1);
    host_write(6, 24'h0000F3, 1, 1);
    run_frame(5, 1, 0, 0, 0);
    run_frame(6, 1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_sticky", err_invalid, 1);
    run_frame(5, 1, 0, 0, 0);

    host_write(4094, 24'h0A0B0C, 1, 1);
    host_write(1, 24'h102030, 1, 1);
    host_write(4, 24'h405060, 1, 1);
    run_frame(4094, 3, 3, 0, 0);

    ready_mode = 2;
    rcnt = 0;
    run_frame(300, 8, 2, 0, 0);
    ready_mode = 0;

    run_frame(77, 0, 1, 0, 0);
    run_frame(512, 8, 1, 0, 1);
    run_frame(16, 1, 0, 0, 0);

    e = push_frame(256, 8, 1);
    beats_acc = 0;
    cfg_base = 12'd256; cfg_depth = 16'd8; cfg_stride = 8'd1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (beats_acc < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rst_reach_beat3", (beats_acc >= 3), 1);
    #2 reset = 1;
    #1;
    chk("midrst_clear", {busy, done, out_valid, out_last, out_weights}, '0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 0;
    dcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    run_frame(256, 8, 1, 1, 0);

    for (int f = 0; f < 8; f++) begin
      ready_mode = $urandom_range(0, 2);
      run_frame($urandom_range(0, 4095), $urandom_range(1, 24), $urandom_range(0, 255), 0, 0);
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
